// File: rtl/cache_pkg.sv
// Shared types and geometry for the cache line-fill sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Geometry: 128 lines of 16 B, address = tag[15:11] | index[10:4] | offset[3:0].
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int WORDS_PER_BLOCK = 8;   // 16-bit words per line
    localparam int OFFSET_BITS     = 4;   // byte-offset bits per line
    localparam int INDEX_BITS      = 7;
    localparam int TAG_BITS        = 5;
    localparam int WORD_OFF_BITS   = 3;   // word slot within a line

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Resettable, enable-gated up-counter with clear that saturates at MAX_VAL.
// Latency: count updates on the clock edge following clr/en.
// Backpressure: none; en simply holds the count when low.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-low reset
//   clr  - synchronous clear, wins over en
//   en   - count enable
//   cnt  - current count
module fill_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX_CNT)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill sequencer: fetches one line as WORDS_PER_BLOCK words, writes data then tag.
// Latency: first request the cycle after the miss is sampled; busy for 8+L cycles at memory latency L.
// Backpressure: memory accepts one request per cycle; the pipeline is held via fsm_busy.
//
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   miss_detected     - tag-compare miss, sampled only in IDLE
//   miss_address      - byte address of the missing access
//   memory_data_valid - one returned word this cycle (ignored in IDLE)
//   fsm_busy          - fill in progress
//   memory_read       - read request this cycle, memory_address is the word address
//   write_data_array  - write returned word at fill_word_offset
//   write_tag_array   - write latched tag, valid=1, at latched index
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_WIDTH      = 16,
    parameter int OFFSET_BITS     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 miss_detected,
    input  logic [ADDR_WIDTH-1:0]                miss_address,
    input  logic                                 memory_data_valid,
    output logic                                 fsm_busy,
    output logic                                 memory_read,
    output logic [ADDR_WIDTH-1:0]                memory_address,
    output logic                                 write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0]   fill_word_offset,
    output logic                                 write_tag_array
);

    localparam int WB     = $clog2(WORDS_PER_BLOCK);
    localparam int BASE_W = ADDR_WIDTH - OFFSET_BITS;
    localparam int PAD    = OFFSET_BITS - WB;   // byte bits below the word index

    localparam logic [WB:0]   ISSUE_END = (WB+1)'(WORDS_PER_BLOCK);
    localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_BLOCK - 1);

    state_t              state;
    logic [BASE_W-1:0]   base;
    logic [WB:0]         issue_cnt;
    logic [WB-1:0]       ret_cnt;

    logic in_fill;
    logic take_miss;
    logic fill_done;
    logic issue_en;
    logic ret_en;

    // Byte offset of the missing access does not matter: the line is always filled from word 0.
    logic unused_miss_offset;
    assign unused_miss_offset = ^miss_address[OFFSET_BITS-1:0];

    assign in_fill   = (state == FILL);
    assign take_miss = (state == IDLE) && miss_detected;
    assign fill_done = in_fill && memory_data_valid && (ret_cnt == LAST_WORD);
    assign issue_en  = in_fill && (issue_cnt < ISSUE_END);
    assign ret_en    = in_fill && memory_data_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        state <= FILL;
                        base  <= miss_address[ADDR_WIDTH-1:OFFSET_BITS];
                    end
                end
                FILL: begin
                    // A miss arriving with the last word is not taken here;
                    // it is sampled again from IDLE on the next edge.
                    if (fill_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request side: saturates one past the last word so memory_read drops cleanly.
    fill_counter #(
        .WIDTH   (WB + 1),
        .MAX_VAL (WORDS_PER_BLOCK)
    ) u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .clr (take_miss || fill_done),
        .en  (issue_en),
        .cnt (issue_cnt)
    );

    // Return side: the clear on the final word doubles as the 7->0 wrap.
    fill_counter #(
        .WIDTH   (WB),
        .MAX_VAL (WORDS_PER_BLOCK - 1)
    ) u_ret_cnt (
        .clk (clk),
        .rst (rst),
        .clr (take_miss || fill_done),
        .en  (ret_en),
        .cnt (ret_cnt)
    );

    assign fsm_busy         = in_fill;
    assign memory_read      = issue_en;
    assign memory_address   = memory_read ? {base, issue_cnt[WB-1:0], {PAD{1'b0}}}
                                          : '0;
    assign write_data_array = ret_en;
    assign fill_word_offset = in_fill ? ret_cnt : '0;
    assign write_tag_array  = fill_done;

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling sequencer for the direct-mapped cache: 128 lines of 16 B, address split as tag[15:11], index[10:4], offset[3:0].
- On a miss it fetches the whole 16 B line as eight 16-bit words from pipelined main memory.
- It writes each returned word into the data array, then writes the tag/valid entry.
- It holds the pipeline stalled for the duration; one instance each serves the I-cache and the D-cache.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache line; must be a power of 2.
- ADDR_WIDTH, 16, byte address width.
- OFFSET_BITS, 4, byte-offset bits per line (log2 of 16 B).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- miss_detected  in  1  tag-compare miss for the current access
- miss_address  in  16  byte address of the missing access
- memory_data_valid  in  1  main memory returns one word this cycle
- fsm_busy  out  1  fill in progress; upstream ORs this with miss_detected to form stall
- memory_read  out  1  read request to memory this cycle
- memory_address  out  16  byte address of the requested word
- write_data_array  out  1  write the word on the memory data bus into the data array
- fill_word_offset  out  3  word slot (0..7) within the line being written
- write_tag_array  out  1  write the latched tag plus valid=1 at the latched index

Behaviour:
- States: IDLE, FILL. State is a registered 1-bit flop; all outputs are decoded combinationally from state and counters.
- Reset (rst==0 at an edge): state=IDLE, issue_cnt=0, ret_cnt=0, base address=0. All outputs are 0 while in IDLE after reset.
- IDLE:
  - All outputs 0.
  - If miss_detected==1 at an edge: latch base = miss_address[15:4], clear both counters, go to FILL.
  - memory_data_valid is ignored in IDLE.
- FILL, request side:
  - issue_cnt is 4 bits. memory_read = (issue_cnt < 8).
  - memory_address = {base, issue_cnt[2:0], 1'b0}, i.e. word-aligned and ascending from offset 0.
  - issue_cnt increments every cycle while < 8. Memory accepts one request per cycle with no back-pressure.
  - When memory_read==0, memory_address is 0.
- FILL, return side:
  - write_data_array = memory_data_valid; fill_word_offset = ret_cnt[2:0].
  - ret_cnt increments on each valid. Words are assumed returned in request order.
- Completion:
  - In the cycle memory_data_valid==1 and ret_cnt==7, write_tag_array=1 (same cycle as the last data write).
  - Next state is IDLE and counters clear.
- fsm_busy = (state==FILL).
- Timing: with memory latency L and back-to-back returns, fsm_busy is high for 8+L cycles starting the cycle after miss_detected is sampled.
- miss_detected during FILL is ignored; the latched base does not change.
- A miss in the same cycle as completion is not accepted that cycle. The FSM returns to IDLE for at least one cycle. Upstream stall stays high via miss_detected, and the miss is taken on the next edge.
- memory_data_valid while ret_cnt would exceed 7 cannot occur by protocol. The FSM never writes past offset 7.
- Reset mid-fill:
  - Immediate return to IDLE with no tag write; the line stays invalid or stale-tagged.
  - Late memory returns after reset are ignored (IDLE).
- Counter widths:
  - issue_cnt is 4 bits and saturates at 8.
  - ret_cnt is 3 bits; its 7→0 wrap coincides with the exit to IDLE.

Decomposition:
- Shared package cache_pkg:
  - state encoding (IDLE=0, FILL=1)
  - WORDS_PER_BLOCK, OFFSET_BITS, INDEX_BITS=7, TAG_BITS=5
  - word-offset width = 3
- One natural sub-module: fill_counter, a resettable, enable-gated, saturating up-counter with clear. It is instantiated twice, for issue_cnt and ret_cnt.

Test Plan:
- Basic fill, memory latency 4:
  - Stimulus: miss_address=0x1A36 pulsed with miss_detected.
  - Required: memory_address = 0x1A30, 0x1A32, … 0x1A3E on 8 consecutive cycles.
  - Required: write_data_array with offsets 0..7 on cycles 5..12; write_tag_array only on cycle 12; fsm_busy high cycles 1..12, low on cycle 13.
- Bursty memory:
  - Stimulus: valids with 2-cycle gaps between words.
  - Required: ret_cnt advances only on valid; the tag write occurs exactly with the 8th valid; no extra data writes.
- Ignored inputs:
  - Stimulus: miss_detected toggled with address 0xFFF0 mid-fill of 0x0040.
  - Required: all requests stay within 0x0040..0x004E; base unchanged.
  - Stimulus: memory_data_valid pulses in IDLE.
  - Required: no writes.
- Reset mid-fill:
  - Stimulus: rst=0 after the 3rd returned word.
  - Required: next cycle all outputs 0 and state IDLE.
  - Required: a subsequent valid produces no write; a new miss restarts at offset 0.
- Back-to-back misses:
  - Stimulus: miss_detected held high across the completion cycle with a new address 0x8000.
  - Required: one IDLE cycle, then a second fill requesting from 0x8000.
- Reset polarity and synchronicity:
  - Stimulus: rst high→low between edges during FILL.
  - Required: outputs change only at the next rising edge.
